crossbar_arbiter: RTL and testbench

Round-robin owner arbiter for the 16-port crossbar, sitting opposite the crossbar control FSM. It consumes the controller's `set_owner` / `clr_owner` commands together with the raw request vector and produces the one-hot `grant` vector that the controller watches to detect end of ownership. It holds ownership fairly across sessions and exposes owner identity, hold-time and protocol-error status for debug.

---
 rtl/crossbar_pkg.sv | 17 +
 rtl/rr_pick16.sv | 45 ++++
 rtl/crossbar_arbiter.sv | 93 +++++++++
 tb/tb_crossbar_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// crossbar_pkg
//   Shared constants and types for the 16-port crossbar: the owner arbiter,
//   the crossbar control FSM and the datapath mux all use these.
package crossbar_pkg;

    localparam int NUM_PORTS = 16;
    localparam int ID_W      = 4;

    typedef logic [NUM_PORTS-1:0] port_vec_t;
    typedef logic [ID_W-1:0]      port_id_t;

    // One-hot vector with only bit `id` set.
    function automatic port_vec_t onehot(input port_id_t id);
        return port_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// rr_pick16
//   Combinational round-robin picker. Returns the first set bit of `req`
//   scanning indices ptr, ptr+1, ... mod 16.
//
// Ports
//   req        in   16  request vector, bit i = master i
//   ptr        in    4  index with highest priority
//   pick_id    out   4  winning index (meaningful only when pick_valid = 1)
//   pick_valid out   1  req is non-zero
module rr_pick16
    import crossbar_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic [ID_W-1:0]      pick_id,
    output logic                 pick_valid
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [ID_W-1:0]        enc;

    // Rotating right by ptr puts master `ptr` at bit 0, so a plain
    // lowest-index priority encoder yields the offset from ptr.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: NUM_PORTS];
    end

    always_comb begin
        enc = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                enc = ID_W'(i);
            end
        end
    end

    // Adding ptr back wraps naturally in ID_W bits.
    always_comb begin
        pick_id    = enc + ptr;
        pick_valid = |req;
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter
//   Round-robin owner arbiter for the 16-port crossbar. Elects an owner on a
//   set_owner pulse, holds the one-hot grant until clr_owner, and advances
//   the round-robin pointer past the released owner.
//
// Ports
//   clk          in    1       system clock, rising edge
//   rst_n        in    1       asynchronous active-low reset
//   request      in   16       per-master request
//   set_owner    in    1       elect a new owner this cycle
//   clr_owner    in    1       release the current owner this cycle
//   grant        out  16       registered one-hot grant, zero when idle
//   owner_id     out   4       current owner index (valid with owner_valid)
//   owner_valid  out   1       an owner is granted
//   hold_cnt     out  HOLD_W   cycles the owner has held grant, saturating
//   proto_err    out   1       sticky protocol-violation flag
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int HOLD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] request,
    input  logic                 set_owner,
    input  logic                 clr_owner,
    output logic [NUM_PORTS-1:0] grant,
    output logic [ID_W-1:0]      owner_id,
    output logic                 owner_valid,
    output logic [HOLD_W-1:0]    hold_cnt,
    output logic                 proto_err
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] pick_id;
    logic            pick_valid;
    logic            elect;
    logic            do_release;
    logic            violation;
    logic            hold_sat;

    rr_pick16 u_pick (
        .req        (request),
        .ptr        (ptr),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    // Release wins over a simultaneous set; a set is only honoured from idle
    // with at least one requester.
    always_comb begin
        do_release = clr_owner & owner_valid;
        elect      = set_owner & ~clr_owner & ~owner_valid & pick_valid;
        violation  = (set_owner & clr_owner)
                   | (set_owner & owner_valid)
                   | (set_owner & ~pick_valid)
                   | (clr_owner & ~owner_valid);
        hold_sat   = &hold_cnt;
    end

    // The grant is never dropped on its own: only clr_owner (or reset)
    // ends ownership, even after the owner's request has fallen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            owner_id    <= '0;
            owner_valid <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else if (do_release) begin
            grant       <= '0;
            owner_valid <= 1'b0;
            hold_cnt    <= '0;
            ptr         <= owner_id + ID_W'(1);
        end else if (elect) begin
            grant       <= onehot(pick_id);
            owner_id    <= pick_id;
            owner_valid <= 1'b1;
            hold_cnt    <= '0;
        end else if (owner_valid && !hold_sat) begin
            hold_cnt    <= hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (violation) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_crossbar_arbiter.sv
module tb_crossbar_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] request = '0;
    logic        set_owner = 1'b0;
    logic        clr_owner = 1'b0;

    logic [15:0] grant, grant4;
    logic [3:0]  owner_id, owner_id4;
    logic        owner_valid, owner_valid4;
    logic [15:0] hold_cnt;
    logic [3:0]  hold_cnt4;
    logic        proto_err, proto_err4;

    crossbar_arbiter dut (
        .clk(clk), .rst_n(rst_n), .request(request),
        .set_owner(set_owner), .clr_owner(clr_owner),
        .grant(grant), .owner_id(owner_id), .owner_valid(owner_valid),
        .hold_cnt(hold_cnt), .proto_err(proto_err)
    );

    crossbar_arbiter #(.HOLD_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .request(request),
        .set_owner(set_owner), .clr_owner(clr_owner),
        .grant(grant4), .owner_id(owner_id4), .owner_valid(owner_valid4),
        .hold_cnt(hold_cnt4), .proto_err(proto_err4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), pointer, unsaturated hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_err   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_err   = 1'b0;
        end else begin
            bit s, c;
            s = set_owner;
            c = clr_owner;
            if ((s && c) || (s && m_owner >= 0) || (s && request == 0) || (c && m_owner < 0))
                m_err = 1'b1;
            if (c && m_owner >= 0) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_hold  = 0;
            end else if (m_owner >= 0) begin
                if (m_hold < 100000) m_hold++;
            end else if (s && !c && request != 0) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_owner < 0 && request[(m_ptr + i) % 16]) m_owner = (m_ptr + i) % 16;
                end
                m_hold = 0;
            end
        end
    end

    function automatic logic [31:0] exp_grant();
        return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_hold(input int w);
        int mx;
        mx = (1 << w) - 1;
        return (m_hold > mx) ? mx : m_hold;
    endfunction

    always @(negedge clk) begin
        if (armed && rst_n) begin
            chk("grant", {16'h0, grant}, exp_grant());
            chk("owner_valid", {31'h0, owner_valid}, {31'h0, m_owner >= 0});
            if (m_owner >= 0) chk("owner_id", {28'h0, owner_id}, m_owner);
            chk("hold_cnt", {16'h0, hold_cnt}, exp_hold(16));
            chk("proto_err", {31'h0, proto_err}, {31'h0, m_err});
            chk("grant4", {16'h0, grant4}, exp_grant());
            chk("hold_cnt4", {28'h0, hold_cnt4}, exp_hold(4));
            chk("proto_err4", {31'h0, proto_err4}, {31'h0, m_err});
        end
    end

    // Drive one cycle of inputs; returns #1 after the edge that consumed them.
    task automatic step(input logic [15:0] r, input logic s, input logic c);
        request   = r;
        set_owner = s;
        clr_owner = c;
        @(posedge clk);
        #1;
        set_owner = 1'b0;
        clr_owner = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        armed = 1'b1;
        chk("rst_grant", {16'h0, grant}, 32'h0);
        chk("rst_valid", {31'h0, owner_valid}, 32'h0);
        chk("rst_hold", {16'h0, hold_cnt}, 32'h0);
        chk("rst_err", {31'h0, proto_err}, 32'h0);

        // single requester election and hold
        step(16'h0001, 1'b1, 1'b0);
        chk("elect0_grant", {16'h0, grant}, 32'h0001);
        chk("elect0_id", {28'h0, owner_id}, 32'h0);
        chk("elect0_hold", {16'h0, hold_cnt}, 32'h0);
        repeat (4) step(16'h0001, 1'b0, 1'b0);
        chk("hold5", {16'h0, hold_cnt}, 32'h4);
        step(16'h0000, 1'b0, 1'b1);
        chk("rel0_grant", {16'h0, grant}, 32'h0);

        // rotation across 8004
        step(16'h8004, 1'b1, 1'b0);
        chk("rr_first", {16'h0, grant}, 32'h0004);
        step(16'h8004, 1'b0, 1'b1);
        chk("model_ptr3", m_ptr, 32'd3);
        step(16'h8004, 1'b1, 1'b0);
        chk("rr_second", {16'h0, grant}, 32'h8000);
        chk("rr_second_id", {28'h0, owner_id}, 32'hF);
        step(16'h0000, 1'b0, 1'b1);
        chk("model_ptr_wrap", m_ptr, 32'd0);
        step(16'hFFFF, 1'b1, 1'b0);
        chk("wrap_grant", {16'h0, grant}, 32'h0001);
        chk("no_err_yet", {31'h0, proto_err}, 32'h0);

        // simultaneous set and clear while owner 2 is active
        step(16'hFFFF, 1'b0, 1'b1);
        step(16'h0004, 1'b1, 1'b0);
        chk("own2", {16'h0, grant}, 32'h0004);
        step(16'h0004, 1'b1, 1'b1);
        chk("setclr_grant", {16'h0, grant}, 32'h0);
        chk("setclr_err", {31'h0, proto_err}, 32'h1);
        step(16'hFFFF, 1'b1, 1'b0);
        chk("setclr_ptr3", {16'h0, grant}, 32'h0008);

        // long hold saturates the narrow counter
        repeat (19) step(16'h0000, 1'b0, 1'b0);
        chk("hold20", {16'h0, hold_cnt}, 32'd19);
        chk("hold20_sat4", {28'h0, hold_cnt4}, 32'd15);
        chk("still_granted", {16'h0, grant}, 32'h0008);

        // asynchronous reset mid-hold, no clock edge in between
        rst_n = 1'b0;
        #1;
        chk("async_grant", {16'h0, grant}, 32'h0);
        chk("async_grant4", {16'h0, grant4}, 32'h0);
        chk("async_valid", {31'h0, owner_valid}, 32'h0);
        chk("async_err", {31'h0, proto_err}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // lone clear when idle
        step(16'h0000, 1'b0, 1'b1);
        chk("lone_clr_err", {31'h0, proto_err}, 32'h1);
        chk("lone_clr_valid", {31'h0, owner_valid}, 32'h0);
        step(16'h0002, 1'b1, 1'b0);
        chk("after_lone_clr", {16'h0, grant}, 32'h0002);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] r;
            case ($urandom_range(0, 3))
                0: r = 16'h0;
                1: r = 16'(1 << $urandom_range(0, 15));
                2: r = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
                default: r = 16'($urandom);
            endcase
            step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
